// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer (master) and the cpu (slave).
interface instr_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              load;
  logic              s;
  logic              w;
  logic [DATA_W-1:0] instr_out;

  modport master (output load, output s, output instr_out, input w);
  modport slave  (input load, input s, input instr_out, output w);
endinterface

// File: rtl/instr_sequencer.sv
// Steps through a small program store, handing each word to the cpu with a
// load/s pulse pair and waiting for w to fall and rise before the next one.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [DATA_W-1:0]     prog_data,
  input  logic [ADDR_W:0]       num_instr,
  input  logic                  go,
  instr_sequencer_if.master     bus,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W:0]       issued,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W:0]     issued_q, issued_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W:0]     issued_inc;
  logic                prog_ok;

  assign pc_inc     = pc_q + 1'b1;
  assign issued_inc = issued_q + 1'b1;
  assign prog_ok    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

  // The store is never reset; writes land only while no sequence is running.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      issued_q <= '0;
      instr_q  <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      instr_q  <= instr_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    instr_d  = instr_q;
    wdog_d   = wdog_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (num_instr == '0) begin
            state_d  = S_DONE;
            pc_d     = '0;
            issued_d = '0;
            err_d    = 1'b0;
          end else if (bus.w) begin
            state_d  = S_LOAD;
            pc_d     = '0;
            issued_d = '0;
            err_d    = 1'b0;
            wdog_d   = '0;
            instr_d  = mem_q[ADDR_W'(0)];
          end
        end
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.w) begin
          wdog_d  = '0;
          state_d = S_WAIT_HI;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WD_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT_HI: begin
        if (bus.w) begin
          issued_d = issued_inc;
          pc_d     = pc_inc;
          if (issued_inc == num_instr) begin
            state_d = S_DONE;
          end else begin
            instr_d = mem_q[pc_inc];
            state_d = S_LOAD;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WD_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: if (!go) state_d = S_IDLE;
      S_ERR:  if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.load      = (state_q == S_LOAD);
  assign bus.s         = (state_q == S_START);
  assign bus.instr_out = instr_q;
  assign pc            = pc_q;
  assign issued        = issued_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_START) ||
                         (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a cpu handshake stub plus a scoreboard of the words
// expected at each load pulse.
module tb_instr_sequencer;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [ADDR_W:0]   num_instr;
  logic              go;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   issued;
  logic              busy, done, err;

  instr_sequencer_if #(.DATA_W(DATA_W)) cif ();

  instr_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .num_instr (num_instr),
    .go        (go),
    .bus       (cif),
    .pc        (pc),
    .issued    (issued),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int s_cnt = 0;
  logic prev_load = 1'b0;
  bit hang = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // cpu stub: one cycle after s, drop w for three cycles, then raise it again
  initial begin
    cif.w = 1'b1;
    forever begin
      @(negedge clk);
      if (cif.s === 1'b1 && !hang) begin
        @(negedge clk);
        cif.w = 1'b0;
        repeat (3) @(negedge clk);
        cif.w = 1'b1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (cif.load === 1'b1) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL load_unexpected actual=%0h required=no_load", cif.instr_out);
      end else begin
        chk("instr_at_load", 32'(cif.instr_out), 32'(exp_q.pop_front()));
      end
    end
    if (cif.s === 1'b1) begin
      s_cnt++;
      chk("s_after_load", 32'(prev_load), 32'd1);
    end
    prev_load = cif.load;
  end

  task automatic write_mem(input int a, input logic [DATA_W-1:0] d);
    prog_addr = ADDR_W'(a);
    prog_data = d;
    prog_we   = 1'b1;
    model_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max);
    int n;
    n = 0;
    while (!(done || err) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=done_or_err", name, n);
    end
  endtask

  task automatic wait_s(input string name, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cif.s !== 1'b1 && n < max);
    if (cif.s !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=s_pulse", name, n);
    end
  endtask

  task automatic run_seq(input string name, input int n, input int exp_pc);
    int lc0, sc0;
    lc0 = load_cnt;
    sc0 = s_cnt;
    num_instr = (ADDR_W+1)'(n);
    for (int k = 0; k < n; k++) exp_q.push_back(model_mem[k % 16]);
    go = 1'b1;
    @(negedge clk);
    chk({name, "_first_load"}, 32'(cif.load), 32'd1);
    wait_end(name, 600);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_issued"}, 32'(issued), 32'(n));
    chk({name, "_pc"}, 32'(pc), 32'(exp_pc));
    @(negedge clk);
    chk({name, "_loads"}, 32'(load_cnt - lc0), 32'(n));
    chk({name, "_s_pulses"}, 32'(s_cnt - sc0), 32'(n));
    go = 1'b0;
    @(negedge clk);
    chk({name, "_done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, lc0, sc0;
    reset = 1'b1; go = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; num_instr = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_load", 32'(cif.load), 32'd0);
    chk("rst_s", 32'(cif.s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_instr", 32'(cif.instr_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // three-instruction program
    write_mem(0, 16'hD007);
    write_mem(1, 16'hD102);
    write_mem(2, 16'hA148);
    run_seq("prog3", 3, 3);

    // single instruction
    write_mem(0, 16'hD305);
    run_seq("single", 1, 1);

    // zero-length request
    lc0 = load_cnt; sc0 = s_cnt;
    num_instr = '0;
    go = 1'b1;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_issued", 32'(issued), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    go = 1'b0;
    @(negedge clk);
    chk("zero_loads", 32'(load_cnt - lc0), 32'd0);
    chk("zero_s", 32'(s_cnt - sc0), 32'd0);

    // cpu never drops w: watchdog
    hang = 1'b1;
    num_instr = 5'd1;
    exp_q.push_back(16'hD305);
    go = 1'b1;
    wait_s("hang_s", 10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (err !== 1'b1 && n < 400);
    chk("wdog_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("wdog_err", 32'(err), 32'd1);
    chk("wdog_busy", 32'(busy), 32'd0);
    lc0 = load_cnt;
    repeat (5) @(negedge clk);
    chk("wdog_no_load", 32'(load_cnt - lc0), 32'd0);
    go = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("err_sticky_idle", 32'(err), 32'd1);
    chk("err_idle_busy", 32'(busy), 32'd0);
    num_instr = '0;
    go = 1'b1;
    @(negedge clk);
    chk("err_cleared_by_go", 32'(err), 32'd0);
    chk("err_go_done", 32'(done), 32'd1);
    go = 1'b0;
    @(negedge clk);

    // reset while waiting for w to rise on the second instruction
    write_mem(0, 16'hD007);
    num_instr = 5'd3;
    exp_q.push_back(16'hD007);
    exp_q.push_back(16'hD102);
    go = 1'b1;
    wait_s("rst_s1", 20);
    wait_s("rst_s2", 20);
    repeat (2) @(negedge clk);
    chk("busy_wait_hi", 32'(busy), 32'd1);
    reset = 1'b1;
    go = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_load", 32'(cif.load), 32'd0);
    chk("midrst_s", 32'(cif.s), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_issued", 32'(issued), 32'd0);
    chk("midrst_instr", 32'(cif.instr_out), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    // write attempt while busy is dropped
    num_instr = 5'd3;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_mem[k]);
    go = 1'b1;
    wait_s("busy_wr_s", 20);
    prog_addr = '0;
    prog_data = 16'hFFFF;
    prog_we = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    wait_end("busy_wr", 200);
    chk("busy_wr_issued", 32'(issued), 32'd3);
    go = 1'b0;
    @(negedge clk);
    run_seq("rerun_mem0", 1, 1);

    // longer than the store: pc wraps
    for (int i = 0; i < 16; i++) write_mem(i, 16'(16'hC000 | (i << 4) | (15 - i)));
    run_seq("wrap18", 18, 2);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
